// File: rtl/jk_sched_pkg.sv
// Shared definitions for the JK command scheduler: op encodings, FSM states
// and the op -> j/k mapping used to drive the flip-flop bank.
package jk_sched_pkg;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_CLR  = 2'b01;
   localparam logic [1:0] OP_SET  = 2'b10;
   localparam logic [1:0] OP_TGL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Returns {j, k} for a command op.
   function automatic logic [1:0] op_to_jk(input logic [1:0] op);
      logic [1:0] jk;
      case (op)
         OP_CLR:  jk = 2'b01;
         OP_SET:  jk = 2'b10;
         OP_TGL:  jk = 2'b11;
         default: jk = 2'b00;
      endcase
      return jk;
   endfunction

endpackage

// File: rtl/jk_cmd_scheduler_if.sv
// Command request channel between one requester and the JK command scheduler.
// Handshake: a command transfers in the cycle where valid && ready are both high;
// ready is a single-cycle pulse and is never raised while the scheduler is busy.
interface jk_cmd_scheduler_if #(
   parameter int IDX_W = 2,
   parameter int CNT_W = 4
);
   logic             valid;
   logic [IDX_W-1:0] idx;
   logic [1:0]       op;
   logic [CNT_W-1:0] cnt;
   logic             ready;

   modport master (output valid, idx, op, cnt, input ready);
   modport slave  (input valid, idx, op, cnt, output ready);
endinterface

// File: rtl/jk_bank.sv
// Bank of N_FF JK flip-flops sharing one j/k pair, with a per-bit update enable.
module jk_bank #(
   parameter int N_FF = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_FF-1:0] en,
   input  logic            j,
   input  logic            k,
   output logic [N_FF-1:0] q,
   output logic [N_FF-1:0] q_bar
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         q <= '0;
      end else begin
         for (int i = 0; i < N_FF; i++) begin
            if (en[i]) begin
               case ({j, k})
                  2'b01:   q[i] <= 1'b0;
                  2'b10:   q[i] <= 1'b1;
                  2'b11:   q[i] <= ~q[i];
                  default: q[i] <= q[i];
               endcase
            end
         end
      end
   end

   assign q_bar = ~q;

endmodule

// File: rtl/jk_cmd_scheduler.sv
// Arbitrates two command requesters onto a shared JK flip-flop bank.
// Define JKS_FIXED_PRIO_EN to give requester 0 fixed priority instead of round robin.
import jk_sched_pkg::*;

module jk_cmd_scheduler #(
   parameter int N_FF  = 4,
   parameter int CNT_W = 4,
   parameter int IDX_W = (N_FF <= 2) ? 1 : $clog2(N_FF)
) (
   input  logic                clk,
   input  logic                reset,
   jk_cmd_scheduler_if.slave   req0,
   jk_cmd_scheduler_if.slave   req1,
   output logic [N_FF-1:0]     q,
   output logic [N_FF-1:0]     q_bar,
   output logic                busy,
   output logic                done,
   output logic                grant_id,
   output logic                err,
   output state_t              dbg_state
);

   state_t           state, state_nx;
   logic [IDX_W-1:0] idx_r;
   logic [1:0]       op_r;
   logic [CNT_W-1:0] rem_r;
   logic             grant_r;
   logic             win;
   logic             accept;
   logic [CNT_W-1:0] sel_cnt;
   logic [N_FF-1:0]  en;
   logic [1:0]       jk;
   logic             oor;

`ifdef JKS_FIXED_PRIO_EN
   assign win = ~req0.valid;
`else
   // prio_r names the requester that wins a tie: the one not granted last.
   logic prio_r;
   assign win = (req0.valid && req1.valid) ? prio_r : req1.valid;

   always_ff @(posedge clk) begin
      if (!reset)      prio_r <= 1'b0;
      else if (accept) prio_r <= ~win;
   end
`endif

   assign accept     = reset && (state == IDLE) && (req0.valid || req1.valid);
   assign req0.ready = accept && !win;
   assign req1.ready = accept && win;
   assign sel_cnt    = win ? req1.cnt : req0.cnt;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = ISSUE;
         ISSUE:   if (rem_r == CNT_W'(1)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         idx_r   <= '0;
         op_r    <= OP_HOLD;
         rem_r   <= '0;
         grant_r <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            idx_r   <= win ? req1.idx : req0.idx;
            op_r    <= win ? req1.op  : req0.op;
            rem_r   <= (sel_cnt == '0) ? CNT_W'(1) : sel_cnt;
            grant_r <= win;
         end else if (state == ISSUE) begin
            rem_r <= rem_r - CNT_W'(1);
         end
      end
   end

   // An out-of-range index matches no enable bit, so the bank is left untouched.
   always_comb begin
      en = '0;
      for (int i = 0; i < N_FF; i++) begin
         en[i] = (state == ISSUE) && (idx_r == IDX_W'(i));
      end
   end

   assign oor       = ({1'b0, idx_r} >= (IDX_W + 1)'(N_FF));
   assign jk        = op_to_jk(op_r);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign err       = (state == DONE) && oor;
   assign grant_id  = grant_r;
   assign dbg_state = state;

   jk_bank #(.N_FF(N_FF)) u_bank (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .j     (jk[1]),
      .k     (jk[0]),
      .q     (q),
      .q_bar (q_bar)
   );

endmodule

// File: tb/tb_jk_cmd_scheduler.sv
// Directed bench for jk_cmd_scheduler: N_FF=4, index widened to 3 bits so
// out-of-range commands can be issued.
import jk_sched_pkg::*;

module tb_jk_cmd_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] q, q_bar;
   logic       busy, done, grant_id, err;
   state_t     dbg_state;
   int         errors = 0;
   int         checks = 0;

   jk_cmd_scheduler_if #(.IDX_W(3), .CNT_W(4)) req0_if ();
   jk_cmd_scheduler_if #(.IDX_W(3), .CNT_W(4)) req1_if ();

   jk_cmd_scheduler #(.N_FF(4), .CNT_W(4), .IDX_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0_if),
      .req1      (req1_if),
      .q         (q),
      .q_bar     (q_bar),
      .busy      (busy),
      .done      (done),
      .grant_id  (grant_id),
      .err       (err),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives a command on one requester until accepted; returns in cycle T+1.
   task automatic send(input bit r, input logic [2:0] idx, input logic [1:0] op,
                       input logic [3:0] cnt, output bit ok);
      ok = 1'b0;
      if (r) begin
         req1_if.idx = idx; req1_if.op = op; req1_if.cnt = cnt; req1_if.valid = 1'b1;
      end else begin
         req0_if.idx = idx; req0_if.op = op; req0_if.cnt = cnt; req0_if.valid = 1'b1;
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((r ? req1_if.ready : req0_if.ready) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      step();
      if (r) req1_if.valid = 1'b0;
      else   req0_if.valid = 1'b0;
   endtask

   // Called in cycle T+1; returns at the negedge of the done cycle with n = cycles after T.
   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            n = i;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      req0_if.valid = 1'b1; req0_if.idx = 3'd0; req0_if.op = OP_SET; req0_if.cnt = 4'd1;
      req1_if.valid = 1'b0; req1_if.idx = 3'd0; req1_if.op = OP_HOLD; req1_if.cnt = 4'd0;
      reset = 1'b0;
      step(); step();
      @(negedge clk);
      checks++; if (q !== 4'b0000) begin errors++; $display("FAIL reset_q: got %b expected 0000", q); end
      checks++; if (q_bar !== 4'b1111) begin errors++; $display("FAIL reset_qbar: got %b expected 1111", q_bar); end
      checks++; if ({busy, done, err, grant_id} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, err, grant_id}); end
      checks++; if (req0_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req0_if.ready); end
      checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
      req0_if.valid = 1'b0;
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_single();
      bit ok;
      int n;
      send(1'b0, 3'd2, OP_SET, 4'd1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_accept: got no ready expected ready"); end
      req0_if.idx = 3'd3; req0_if.op = OP_CLR;
      wait_done(n);
      checks++; if (n !== 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", n); end
      checks++; if (q !== 4'b0100) begin errors++; $display("FAIL single_q: got %b expected 0100", q); end
      checks++; if (q_bar !== 4'b1011) begin errors++; $display("FAIL single_qbar: got %b expected 1011", q_bar); end
      checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL single_grant: got %b expected 0", grant_id); end
      step();
      @(negedge clk);
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL single_idle: got %b expected 00", {busy, done}); end
      step();
   endtask

   task automatic test_toggle();
      bit ok;
      logic exp_seq [3];
      exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b1;
      reset = 1'b0;
      step(); step();
      reset = 1'b1;
      send(1'b1, 3'd0, OP_TGL, 4'd3, ok);
      checks++; if (!ok) begin errors++; $display("FAIL toggle_accept: got no ready expected ready"); end
      @(negedge clk);
      checks++; if (busy !== 1'b1 || dbg_state !== ISSUE) begin errors++; $display("FAIL toggle_busy: got busy=%b state=%0d expected busy=1 state=1", busy, dbg_state); end
      for (int c = 0; c < 3; c++) begin
         step();
         @(negedge clk);
         checks++; if (q[0] !== exp_seq[c]) begin errors++; $display("FAIL toggle_seq%0d: got %b expected %b", c, q[0], exp_seq[c]); end
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL toggle_done: got %b expected 1", done); end
      checks++; if (q !== 4'b0001 || grant_id !== 1'b1) begin errors++; $display("FAIL toggle_final: got q=%b grant=%b expected q=0001 grant=1", q, grant_id); end
      step();
   endtask

   task automatic test_cnt_zero_hold();
      bit ok;
      int n;
      send(1'b0, 3'd1, OP_SET, 4'd2, ok);
      wait_done(n);
      checks++; if (!ok || n !== 3 || q !== 4'b0011) begin errors++; $display("FAIL set_cnt2: got ok=%b n=%0d q=%b expected ok=1 n=3 q=0011", ok, n, q); end
      step();
      send(1'b0, 3'd1, OP_CLR, 4'd0, ok);
      wait_done(n);
      checks++; if (!ok || n !== 2) begin errors++; $display("FAIL cnt0_latency: got ok=%b n=%0d expected ok=1 n=2", ok, n); end
      checks++; if (q !== 4'b0001) begin errors++; $display("FAIL cnt0_q: got %b expected 0001", q); end
      step();
      send(1'b0, 3'd3, OP_HOLD, 4'd5, ok);
      wait_done(n);
      checks++; if (!ok || n !== 6 || q !== 4'b0001 || err !== 1'b0) begin errors++; $display("FAIL hold: got ok=%b n=%0d q=%b err=%b expected ok=1 n=6 q=0001 err=0", ok, n, q, err); end
      step();
   endtask

   task automatic test_simultaneous();
      int n;
      logic [2:0] idx0 [2], idx1 [2];
      logic [1:0] op0 [2], op1 [2];
      logic [3:0] exp_a [2], exp_b [2];
      idx0[0] = 3'd2; op0[0] = OP_SET; idx1[0] = 3'd3; op1[0] = OP_SET;
      idx0[1] = 3'd0; op0[1] = OP_TGL; idx1[1] = 3'd3; op1[1] = OP_CLR;
      exp_a[0] = 4'b1001; exp_b[0] = 4'b1101;
      exp_a[1] = 4'b0101; exp_b[1] = 4'b0100;
      for (int r = 0; r < 2; r++) begin
         req0_if.idx = idx0[r]; req0_if.op = op0[r]; req0_if.cnt = 4'd1; req0_if.valid = 1'b1;
         req1_if.idx = idx1[r]; req1_if.op = op1[r]; req1_if.cnt = 4'd1; req1_if.valid = 1'b1;
         @(negedge clk);
         checks++; if ({req1_if.ready, req0_if.ready} !== 2'b10) begin errors++; $display("FAIL rr%0d_first: got ready1,0=%b expected 10", r, {req1_if.ready, req0_if.ready}); end
         step();
         req1_if.valid = 1'b0;
         wait_done(n);
         checks++; if (n !== 2 || grant_id !== 1'b1 || q !== exp_a[r]) begin errors++; $display("FAIL rr%0d_req1: got n=%0d grant=%b q=%b expected n=2 grant=1 q=%b", r, n, grant_id, q, exp_a[r]); end
         checks++; if (req0_if.ready !== 1'b0) begin errors++; $display("FAIL rr%0d_ready_in_done: got %b expected 0", r, req0_if.ready); end
         step();
         @(negedge clk);
         checks++; if (req0_if.ready !== 1'b1) begin errors++; $display("FAIL rr%0d_pending: got %b expected 1", r, req0_if.ready); end
         step();
         req0_if.valid = 1'b0;
         wait_done(n);
         checks++; if (n !== 2 || grant_id !== 1'b0 || q !== exp_b[r]) begin errors++; $display("FAIL rr%0d_req0: got n=%0d grant=%b q=%b expected n=2 grant=0 q=%b", r, n, grant_id, q, exp_b[r]); end
         step();
      end
   endtask

   task automatic test_cnt_max();
      bit ok;
      int n;
      send(1'b0, 3'd1, OP_TGL, 4'd15, ok);
      wait_done(n);
      checks++; if (!ok || n !== 16) begin errors++; $display("FAIL cntmax_latency: got ok=%b n=%0d expected ok=1 n=16", ok, n); end
      checks++; if (q !== 4'b0110) begin errors++; $display("FAIL cntmax_q: got %b expected 0110", q); end
      step();
   endtask

   task automatic test_out_of_range();
      bit ok;
      int n;
      send(1'b1, 3'd5, OP_TGL, 4'd2, ok);
      wait_done(n);
      checks++; if (!ok || n !== 3) begin errors++; $display("FAIL oor_latency: got ok=%b n=%0d expected ok=1 n=3", ok, n); end
      checks++; if (err !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL oor_err: got err=%b done=%b expected 1 1", err, done); end
      checks++; if (q !== 4'b0110 || q_bar !== 4'b1001 || grant_id !== 1'b1) begin errors++; $display("FAIL oor_q: got q=%b qbar=%b grant=%b expected 0110 1001 1", q, q_bar, grant_id); end
      step();
      @(negedge clk);
      checks++; if ({err, done} !== 2'b00) begin errors++; $display("FAIL oor_pulse: got %b expected 00", {err, done}); end
      step();
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      send(1'b1, 3'd0, OP_TGL, 4'd15, ok);
      @(negedge clk);
      checks++; if (!ok || q !== 4'b0110) begin errors++; $display("FAIL mid_start: got ok=%b q=%b expected 1 0110", ok, q); end
      step();
      @(negedge clk);
      checks++; if (q !== 4'b0111) begin errors++; $display("FAIL mid_first: got %b expected 0111", q); end
      step(); step(); step();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (q !== 4'b0110 || busy !== 1'b1) begin errors++; $display("FAIL mid_t5: got q=%b busy=%b expected 0110 1", q, busy); end
      for (int c = 0; c < 3; c++) begin
         step();
         @(negedge clk);
         checks++; if (done !== 1'b0 || q !== 4'b0000 || busy !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL mid_reset%0d: got done=%b q=%b busy=%b state=%0d expected 0 0000 0 0", c, done, q, busy, dbg_state); end
      end
      step();
      reset = 1'b1;
      send(1'b0, 3'd2, OP_SET, 4'd1, ok);
      wait_done(n);
      checks++; if (!ok || n !== 2 || q !== 4'b0100 || grant_id !== 1'b0) begin errors++; $display("FAIL mid_after: got ok=%b n=%0d q=%b grant=%b expected 1 2 0100 0", ok, n, q, grant_id); end
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_toggle();
      test_cnt_zero_hold();
      test_simultaneous();
      test_cnt_max();
      test_out_of_range();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jk_cmd_scheduler.md
Name: jk_cmd_scheduler

Overview:
- Shares one bank of N_FF JK flip-flops between two command requesters.
- Arbitrates between the requesters and latches the winning command.
- Drives the target flip-flop's j/k inputs for a programmed number of cycles, then signals completion.
- Sits between software-style command sources and the JK storage; it is the only block that writes the bank.

Parameters:
- N_FF, 4, number of JK flip-flops in the bank (2..16).
- CNT_W, 4, width of the per-command repeat count.
- IDX_W, $clog2(N_FF) (minimum 1), width of the flip-flop index.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req0_valid  in  1  requester 0 has a command.
- req0_idx  in  IDX_W  target flip-flop index.
- req0_op  in  2  00 hold, 01 clear, 10 set, 11 toggle.
- req0_cnt  in  CNT_W  number of cycles to apply the op; 0 is treated as 1.
- req0_ready  out  1  one-cycle accept pulse for requester 0.
- req1_valid, req1_idx, req1_op, req1_cnt, req1_ready: same as requester 0, for requester 1.
- q  out  N_FF  bank outputs.
- q_bar  out  N_FF  bitwise inverse of q.
- busy  out  1  high while in ISSUE or DONE.
- done  out  1  one-cycle pulse when a command completes.
- grant_id  out  1  requester owning the current or last command.
- err  out  1  one-cycle pulse, concurrent with done, when the completed command had idx >= N_FF.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; q=0; q_bar=all ones.
  - req0_ready=0, req1_ready=0, done=0, err=0, busy=0.
  - grant_id=0; round-robin pointer favours requester 0.
  - Reset wins over everything. A command in flight is discarded with no done and no further bank updates.
- State IDLE:
  - If any valid is high, choose the winner.
    - Only one valid: that requester wins.
    - Both valid: the requester not granted last wins (round robin).
  - Assert the winner's ready for exactly one cycle. The handshake completes in the same cycle valid&&ready are high.
  - Latch idx, op, and cnt' = (cnt==0 ? 1 : cnt). Set grant_id and update the pointer.
  - Next state ISSUE.
  - The loser's valid is held pending and is not acknowledged.
- State ISSUE:
  - Each cycle, apply the latched op to bank bit idx using standard JK semantics:
    - hold: q unchanged.
    - clear: q=0.
    - set: q=1.
    - toggle: q=~q.
  - Other bits hold.
  - If idx >= N_FF, no bit changes.
  - Decrement the remaining count. When it reaches 0 after the cnt'-th update, go to DONE.
- State DONE:
  - done=1 for one cycle; err=1 in the same cycle if idx was out of range.
  - Next state IDLE.
  - No new request is accepted in DONE.
- Latency, with the accept edge at cycle T:
  - First bank update at T+1, last update at T+cnt'.
  - done is high in cycle T+cnt'+1.
  - The earliest next accept is in the cycle after done.
- ready is never asserted while busy=1.
- A requester that drops valid before ready is simply not served.
- Any change to req*_idx, req*_op or req*_cnt after accept has no effect on the in-flight command.
- Toggle with cnt' even leaves the bit unchanged at completion; with cnt' odd it leaves the bit inverted.
- cnt = max value (2^CNT_W-1) applies that many updates; the counter does not wrap.

Optional Feature:
- Macro: JKS_FIXED_PRIO_EN.
- Defined: requester 0 always wins a simultaneous request; the pointer logic is removed; grant_id still reports the winner.
- Undefined: round-robin arbitration as specified in Behaviour.

Decomposition:
- Shared package jk_sched_pkg holds:
  - op encodings: OP_HOLD=2'b00, OP_CLR=2'b01, OP_SET=2'b10, OP_TGL=2'b11.
  - the state enum: IDLE, ISSUE, DONE.
  - a function mapping op to j/k.
- One sub-module, jk_bank:
  - N_FF JK flip-flops with a per-bit enable.
  - Inputs: clk, reset, en[N_FF], j, k.
  - Outputs: q, q_bar.
- The scheduler contains only the arbiter, the FSM and the counter.

Test Plan:
- Reset then single command: reset=0 for 2 cycles, then req0 {idx=2, op=SET, cnt=1} -> req0_ready pulse at T, q=4'b0100 at T+1, done at T+2, grant_id=0.
- Toggle repeat: q=0, req1 {idx=0, op=TGL, cnt=3} -> q[0] sequence 1,0,1, final q=4'b0001, done at T+4, grant_id=1.
- Simultaneous requests: both valid, last grant=0 -> req1 served first, req0 served after done. Repeat with both valid -> order alternates.
- cnt=0 and hold: req0 {idx=1, op=CLR, cnt=0} -> exactly one update, done at T+2. A HOLD command leaves q unchanged.
- Out-of-range: N_FF=4 with idx forced to 5 (IDX_W widened in the bench) -> q unchanged, done and err both high in the same cycle.
- Reset mid-operation: TGL cnt=15 in progress, reset=0 at T+5 -> q=0, no done, state IDLE; the next request is accepted normally after reset release.
